seri_yon_komut: RTL and testbench

Serial command front-end for the step-motor path: receives 8N1 UART bytes from the host, decodes single-character motion commands, and drives the 2-bit direction word consumed by the step-motor sequencer (`01` = forward sequence, `10` = reverse sequence, `00` = hold last coil pattern). It sits directly upstream of the motor driver, between the board's RX pin and the driver's direction input.

---
 rtl/seri_yon_komut_pkg.sv | 35 +++
 rtl/seri_yon_komut_uart_alici.sv | 123 ++++++++++++
 rtl/seri_yon_komut.sv | 83 ++++++++
 tb/tb_seri_yon_komut.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/seri_yon_komut_pkg.sv
// Shared constants for the serial direction front-end: direction codes,
// command bytes, receiver state encoding and the command decode helper.
package seri_paket;

   localparam logic [1:0] YON_DUR   = 2'b00;
   localparam logic [1:0] YON_ILERI = 2'b01;
   localparam logic [1:0] YON_GERI  = 2'b10;

   localparam logic [7:0] KMT_L_BUYUK = 8'h4C;
   localparam logic [7:0] KMT_L_KUCUK = 8'h6C;
   localparam logic [7:0] KMT_R_BUYUK = 8'h52;
   localparam logic [7:0] KMT_R_KUCUK = 8'h72;
   localparam logic [7:0] KMT_S_BUYUK = 8'h53;
   localparam logic [7:0] KMT_S_KUCUK = 8'h73;

   typedef enum logic [1:0] {
      BOSTA = 2'b00,
      BASLA = 2'b01,
      VERI  = 2'b10,
      DUR   = 2'b11
   } alici_durum_t;

   // Returns {recognised, direction}; unrecognised bytes keep direction at YON_DUR.
   function automatic logic [2:0] komut_coz(input logic [7:0] bayt);
      logic [2:0] sonuc;
      case (bayt)
         KMT_L_BUYUK, KMT_L_KUCUK: sonuc = {1'b1, YON_ILERI};
         KMT_R_BUYUK, KMT_R_KUCUK: sonuc = {1'b1, YON_GERI};
         KMT_S_BUYUK, KMT_S_KUCUK: sonuc = {1'b1, YON_DUR};
         default:                  sonuc = {1'b0, YON_DUR};
      endcase
      return sonuc;
   endfunction

endpackage

// File: rtl/seri_yon_komut_uart_alici.sv
// 8N1 UART receiver: two-flop synchroniser and a four-state receive FSM
// sampling mid-bit, with valid and framing-error pulses.
module uart_alici #(
   parameter int BIT_CYC = 10
) (
   input  logic       saatDarbesi,
   input  logic       rst,
   input  logic       rxGiris,
   output logic [7:0] bayt,
   output logic       baytGecerli,
   output logic       cerceveHata
);
   import seri_paket::*;

   localparam int SW = $clog2(BIT_CYC);
   localparam logic [SW-1:0] SAYAC_SIFIR = SW'(0);
   localparam logic [SW-1:0] SAYAC_BIR   = SW'(1);
   localparam logic [SW-1:0] YARIM_SON   = SW'(BIT_CYC / 2 - 1);
   localparam logic [SW-1:0] TAM_SON     = SW'(BIT_CYC - 1);

   logic          sync1_r, rx_s;
   alici_durum_t  durum_r, durum_n;
   logic [SW-1:0] sayac_r, sayac_n;
   logic [2:0]    bit_r, bit_n;
   logic [7:0]    kaydirici_r, kaydirici_n;
   logic          bekle_r, bekle_n;
   logic          gecerli_r, gecerli_n;
   logic          hata_r, hata_n;

   // Synchroniser and receiver state registers; idle-high line resets to 1.
   always_ff @(posedge saatDarbesi or negedge rst) begin
      if (!rst) begin
         sync1_r     <= 1'b1;
         rx_s        <= 1'b1;
         durum_r     <= BOSTA;
         sayac_r     <= SAYAC_SIFIR;
         bit_r       <= 3'd0;
         kaydirici_r <= 8'h00;
         bekle_r     <= 1'b0;
         gecerli_r   <= 1'b0;
         hata_r      <= 1'b0;
      end else begin
         sync1_r     <= rxGiris;
         rx_s        <= sync1_r;
         durum_r     <= durum_n;
         sayac_r     <= sayac_n;
         bit_r       <= bit_n;
         kaydirici_r <= kaydirici_n;
         bekle_r     <= bekle_n;
         gecerli_r   <= gecerli_n;
         hata_r      <= hata_n;
      end
   end

   // Next-state logic; bekle_r marks a broken stop bit waiting for the line to recover.
   always_comb begin
      durum_n     = durum_r;
      sayac_n     = sayac_r;
      bit_n       = bit_r;
      kaydirici_n = kaydirici_r;
      bekle_n     = bekle_r;
      gecerli_n   = 1'b0;
      hata_n      = 1'b0;
      case (durum_r)
         BOSTA: begin
            sayac_n = SAYAC_SIFIR;
            bekle_n = 1'b0;
            if (!rx_s) begin
               durum_n = BASLA;
               bit_n   = 3'd0;
            end else begin
               durum_n = BOSTA;
            end
         end
         BASLA: begin
            if (sayac_r == YARIM_SON) begin
               sayac_n = SAYAC_SIFIR;
               if (rx_s) durum_n = BOSTA;
               else      durum_n = VERI;
            end else begin
               sayac_n = sayac_r + SAYAC_BIR;
            end
         end
         VERI: begin
            if (sayac_r == TAM_SON) begin
               sayac_n     = SAYAC_SIFIR;
               kaydirici_n = {rx_s, kaydirici_r[7:1]};
               if (bit_r == 3'd7) durum_n = DUR;
               else               bit_n   = bit_r + 3'd1;
            end else begin
               sayac_n = sayac_r + SAYAC_BIR;
            end
         end
         DUR: begin
            if (bekle_r) begin
               if (rx_s) begin
                  durum_n = BOSTA;
                  bekle_n = 1'b0;
               end else begin
                  durum_n = DUR;
               end
            end else if (sayac_r == TAM_SON) begin
               sayac_n = SAYAC_SIFIR;
               if (rx_s) begin
                  gecerli_n = 1'b1;
                  durum_n   = BOSTA;
               end else begin
                  hata_n  = 1'b1;
                  bekle_n = 1'b1;
               end
            end else begin
               sayac_n = sayac_r + SAYAC_BIR;
            end
         end
         default: durum_n = BOSTA;
      endcase
   end

   assign bayt        = kaydirici_r;
   assign baytGecerli = gecerli_r;
   assign cerceveHata = hata_r;

endmodule

// File: rtl/seri_yon_komut.sv
// Serial motion-command front-end: UART receiver, command decoder and direction
// register. Optional idle auto-stop is enabled with SERI_ZAMAN_ASIMI_EN.
module seri_yon_komut #(
   parameter int SAAT_HZ         = 50_000_000,
   parameter int BAUD            = 9600,
   parameter int ZAMAN_ASIMI_CYC = 100_000_000
) (
   input  logic       saatDarbesi,
   input  logic       rst,
   input  logic       rxGiris,
   output logic [1:0] yonCikis,
   output logic       komutGecerli,
   output logic       hataBayragi,
   output logic       zamanAsimi
);
   import seri_paket::*;

   localparam int BIT_CYC = SAAT_HZ / BAUD;

   if (BIT_CYC < 4 || ZAMAN_ASIMI_CYC < 1) begin : g_parametre_hatasi
      $error("seri_yon_komut: BIT_CYC must be >= 4 and ZAMAN_ASIMI_CYC >= 1");
   end

   logic [7:0] bayt_s;
   logic       bayt_gecerli_s, cerceve_hata_s;
   logic [2:0] coz_s;
   logic       tanindi_s, za_tetik_s;
   logic [1:0] yon_r;
   logic       komut_r, hata_r, za_r;

   uart_alici #(.BIT_CYC(BIT_CYC)) u_alici (
      .saatDarbesi (saatDarbesi),
      .rst         (rst),
      .rxGiris     (rxGiris),
      .bayt        (bayt_s),
      .baytGecerli (bayt_gecerli_s),
      .cerceveHata (cerceve_hata_s)
   );

   assign coz_s     = komut_coz(bayt_s);
   assign tanindi_s = bayt_gecerli_s & coz_s[2];

`ifdef SERI_ZAMAN_ASIMI_EN
   localparam logic [31:0] ZA_SON = 32'(ZAMAN_ASIMI_CYC - 1);
   logic [31:0] bos_sayac_r;

   // A command arriving in the same cycle (or just accepted) always beats the timeout.
   assign za_tetik_s = (bos_sayac_r == ZA_SON) & ~komut_r & ~tanindi_s & (yon_r != YON_DUR);

   // Idle counter: cleared by each accepted command, saturates at the timeout point.
   always_ff @(posedge saatDarbesi or negedge rst) begin
      if (!rst)                      bos_sayac_r <= 32'd0;
      else if (komut_r)              bos_sayac_r <= 32'd0;
      else if (bos_sayac_r != ZA_SON) bos_sayac_r <= bos_sayac_r + 32'd1;
      else                           bos_sayac_r <= bos_sayac_r;
   end
`else
   assign za_tetik_s = 1'b0;
`endif

   // Direction register and response pulses.
   always_ff @(posedge saatDarbesi or negedge rst) begin
      if (!rst) begin
         yon_r   <= YON_DUR;
         komut_r <= 1'b0;
         hata_r  <= 1'b0;
         za_r    <= 1'b0;
      end else begin
         komut_r <= tanindi_s;
         hata_r  <= bayt_gecerli_s & ~coz_s[2];
         za_r    <= za_tetik_s;
         if (tanindi_s)       yon_r <= coz_s[1:0];
         else if (za_tetik_s) yon_r <= YON_DUR;
         else                 yon_r <= yon_r;
      end
   end

   assign yonCikis     = yon_r;
   assign komutGecerli = komut_r;
   assign hataBayragi  = hata_r | cerceve_hata_s;
   assign zamanAsimi   = za_r;

endmodule

// File: tb/tb_seri_yon_komut.sv
// Scoreboard bench for seri_yon_komut: each frame pushes its expected pulse
// (kind, cycle, direction) and a negedge monitor pops and compares.
module tb_seri_yon_komut;

   logic       saatDarbesi = 1'b0;
   logic       rst         = 1'b0;
   logic       rxGiris     = 1'b1;
   logic [1:0] yonCikis;
   logic       komutGecerli, hataBayragi, zamanAsimi;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      int         tur;    // 0 command, 1 error, 2 timeout
      int         zaman;
      logic [1:0] yon;
   } olay_t;
   olay_t sb[$];

   seri_yon_komut #(
      .SAAT_HZ         (1_000_000),
      .BAUD            (100_000),
      .ZAMAN_ASIMI_CYC (500)
   ) dut (
      .saatDarbesi  (saatDarbesi),
      .rst          (rst),
      .rxGiris      (rxGiris),
      .yonCikis     (yonCikis),
      .komutGecerli (komutGecerli),
      .hataBayragi  (hataBayragi),
      .zamanAsimi   (zamanAsimi)
   );

   always #5 saatDarbesi = ~saatDarbesi;

   always @(posedge saatDarbesi) cyc <= cyc + 1;

   task automatic bekle(input int n);
      repeat (n) @(posedge saatDarbesi);
      #1;
   endtask

   task automatic chk(input string ad, input logic [1:0] act, input logic [1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", ad, act, exp, cyc);
      end
   endtask

   // Send one 8N1 frame; stop=0 forces a framing error and leaves the line low.
   // tur: -1 nothing expected, 0 command pulse, 1 error pulse.
   task automatic gonder(input logic [7:0] b, input logic stop, input int tur, input logic [1:0] yon);
      int n0;
      n0 = cyc;
      if (tur >= 0) sb.push_back('{tur, n0 + ((stop == 1'b0) ? 98 : 99), yon});
      rxGiris = 1'b0;
      bekle(10);
      for (int i = 0; i < 8; i++) begin
         rxGiris = b[i];
         bekle(10);
      end
      rxGiris = stop;
      bekle(10);
   endtask

   task automatic kontrol(input logic darbe, input int tur, input string ad);
      olay_t e;
      if (darbe) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL %s: unexpected pulse at cycle %0d, yon=%b", ad, cyc, yonCikis);
         end else begin
            e = sb.pop_front();
            if (e.tur != tur || e.zaman != cyc || e.yon !== yonCikis) begin
               fails++;
               $display("FAIL %s: got kind %0d cycle %0d yon %b, expected kind %0d cycle %0d yon %b",
                        ad, tur, cyc, yonCikis, e.tur, e.zaman, e.yon);
            end
         end
      end
   endtask

   // Monitor: every response pulse must match the head of the scoreboard.
   always @(negedge saatDarbesi) begin
      if (yonCikis === 2'b11) begin
         fails++;
         $display("FAIL yon_illegal: got 11 expected never 11 at cycle %0d", cyc);
      end
      kontrol(komutGecerli, 0, "komut");
      kontrol(hataBayragi,  1, "hata");
      kontrol(zamanAsimi,   2, "zaman");
   end

   initial begin
      bekle(3);
      chk("reset_yon",   yonCikis, 2'b00);
      chk("reset_komut", {1'b0, komutGecerli}, 2'b00);
      chk("reset_hata",  {1'b0, hataBayragi},  2'b00);
      chk("reset_zaman", {1'b0, zamanAsimi},   2'b00);
      rst = 1'b1;
      bekle(5);

      // 1: forward command
      gonder(8'h4C, 1'b1, 0, 2'b01);
      bekle(5);
      chk("t1_yon", yonCikis, 2'b01);

      // 2: back-to-back reverse then stop
      gonder(8'h52, 1'b1, 0, 2'b10);
      gonder(8'h73, 1'b1, 0, 2'b00);
      bekle(5);
      chk("t2_yon", yonCikis, 2'b00);

      // 3: unrecognised byte while moving forward
      gonder(8'h6C, 1'b1, 0, 2'b01);
      gonder(8'h41, 1'b1, 1, 2'b01);
      bekle(5);
      chk("t3_yon", yonCikis, 2'b01);

      // 4: framing error, line held low, then a clean reverse
      gonder(8'h53, 1'b1, 0, 2'b00);
      gonder(8'h4C, 1'b0, 1, 2'b00);
      bekle(20);
      rxGiris = 1'b1;
      bekle(5);
      chk("t4_yon_after_err", yonCikis, 2'b00);
      gonder(8'h52, 1'b1, 0, 2'b10);
      bekle(5);
      chk("t4_yon", yonCikis, 2'b10);

      // 5a: reset asserted during bit 4 of an 'L' frame
      rxGiris = 1'b0;
      bekle(10);
      for (int i = 0; i < 4; i++) begin
         rxGiris = (8'h4C >> i) & 8'h01;
         bekle(10);
      end
      rxGiris = 1'b0;
      bekle(5);
      rst     = 1'b0;
      rxGiris = 1'b1;
      bekle(1);
      chk("rst_mid_yon",   yonCikis, 2'b00);
      chk("rst_mid_komut", {1'b0, komutGecerli}, 2'b00);
      chk("rst_mid_hata",  {1'b0, hataBayragi},  2'b00);
      bekle(2);
      rst = 1'b1;
      bekle(20);
      gonder(8'h52, 1'b1, 0, 2'b10);
      bekle(5);
      chk("t5_rst_then_R", yonCikis, 2'b10);

      // 5b: short start glitch is ignored, next frame still decodes
      rxGiris = 1'b0;
      bekle(3);
      rxGiris = 1'b1;
      bekle(30);
      chk("t5_glitch_yon", yonCikis, 2'b10);
      gonder(8'h6C, 1'b1, 0, 2'b01);

      // 6: repeat forward command, then idle
      gonder(8'h4C, 1'b1, 0, 2'b01);
`ifdef SERI_ZAMAN_ASIMI_EN
      sb.push_back('{2, cyc - 1 + 501, 2'b00});
      bekle(600);
      chk("t6_timeout_yon", yonCikis, 2'b00);
`else
      bekle(2000);
      chk("t6_hold_yon", yonCikis, 2'b01);
`endif

      bekle(10);
      while (sb.size() > 0) begin
         olay_t e;
         e = sb.pop_front();
         tests++;
         fails++;
         $display("FAIL missing_pulse: got none, expected kind %0d at cycle %0d yon %b", e.tur, e.zaman, e.yon);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
